comparador_umbral: RTL and testbench

Registered, parametrised threshold comparator for unsigned sample streams. Each accepted sample is compared against programmable high/low thresholds in one of four modes (greater-or-equal, less-than, window, hysteresis). A persistence filter suppresses glitches, and the block emits a filtered level plus one-cycle crossing pulses. It sits between the sample source and the display/alarm logic, replacing direct combinational A-versus-B compares where a stable, debounced decision is needed.

---
 rtl/comparador_umbral_if.sv | 28 ++
 rtl/comparador_umbral.sv | 94 +++++++++
 tb/tb_comparador_umbral.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparador_umbral_if.sv
// Sample/threshold bus for comparador_umbral: the source drives samples and
// configuration, and the comparator returns the filtered decision.
interface comparador_umbral_if #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned PERSIST_W = 4
);
    logic                 enable;
    logic                 dato_valid;
    logic [WIDTH-1:0]     dato;
    logic [WIDTH-1:0]     umbral_alto;
    logic [WIDTH-1:0]     umbral_bajo;
    logic [1:0]           modo;
    logic [PERSIST_W-1:0] persist;
    logic                 salida;
    logic                 cruce_sube;
    logic                 cruce_baja;
    logic [PERSIST_W-1:0] cuenta;

    modport master (
        output enable, dato_valid, dato, umbral_alto, umbral_bajo, modo, persist,
        input  salida, cruce_sube, cruce_baja, cuenta
    );

    modport slave (
        input  enable, dato_valid, dato, umbral_alto, umbral_bajo, modo, persist,
        output salida, cruce_sube, cruce_baja, cuenta
    );
endinterface

// File: rtl/comparador_umbral.sv
// Registered threshold comparator with four compare modes, a persistence filter
// and one-cycle crossing pulses.
module comparador_umbral #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned PERSIST_W = 4
) (
    input logic                clk,
    input logic                rst_n,
    comparador_umbral_if.slave bus
);

    // Bit 1 of the state encoding is the filtered output level.
    typedef enum logic [1:0] {
        StReposoBajo   = 2'b00,
        StConfirmaAlto = 2'b01,
        StReposoAlto   = 2'b10,
        StConfirmaBajo = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [PERSIST_W-1:0] cuenta_q, cuenta_d;
    logic                 sube_q, sube_d;
    logic                 baja_q, baja_d;
    logic                 salida_cur;
    logic                 cand;

    assign salida_cur = state_q[1];

    always_comb begin
        cand = 1'b0;
        case (bus.modo)
            2'b00: cand = (bus.dato >= bus.umbral_alto);
            2'b01: cand = (bus.dato < bus.umbral_bajo);
            2'b10: cand = (bus.dato >= bus.umbral_bajo) && (bus.dato <= bus.umbral_alto);
            default: begin
                // Set wins over clear when the thresholds overlap.
                if (bus.dato >= bus.umbral_alto) begin
                    cand = 1'b1;
                end else if (bus.dato < bus.umbral_bajo) begin
                    cand = 1'b0;
                end else begin
                    cand = salida_cur;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StReposoBajo;
            cuenta_q <= '0;
            sube_q   <= 1'b0;
            baja_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cuenta_q <= cuenta_d;
            sube_q   <= sube_d;
            baja_q   <= baja_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cuenta_d = cuenta_q;
        sube_d   = 1'b0;
        baja_d   = 1'b0;
        if (!bus.enable) begin
            cuenta_d = '0;
            state_d  = salida_cur ? StReposoAlto : StReposoBajo;
        end else if (bus.dato_valid) begin
            if (cand == salida_cur) begin
                cuenta_d = '0;
                state_d  = salida_cur ? StReposoAlto : StReposoBajo;
            end else if (cuenta_q >= bus.persist) begin
                // A lowered persist still flips on the next disagreeing sample.
                cuenta_d = '0;
                state_d  = cand ? StReposoAlto : StReposoBajo;
                sube_d   = cand;
                baja_d   = ~cand;
            end else begin
                cuenta_d = cuenta_q + PERSIST_W'(1);
                state_d  = salida_cur ? StConfirmaBajo : StConfirmaAlto;
            end
        end
    end

    always_comb begin
        bus.salida     = salida_cur;
        bus.cuenta     = cuenta_q;
        bus.cruce_sube = sube_q;
        bus.cruce_baja = baja_q;
    end

endmodule

// File: tb/tb_comparador_umbral.sv
// Directed bench for comparador_umbral: a default build plus an 8-bit build
// with a 2-bit persistence counter.
module tb_comparador_umbral;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    comparador_umbral_if #(.WIDTH(5), .PERSIST_W(4)) bus1 ();
    comparador_umbral_if #(.WIDTH(8), .PERSIST_W(2)) bus2 ();

    comparador_umbral #(.WIDTH(5), .PERSIST_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    comparador_umbral #(.WIDTH(8), .PERSIST_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic accept1(input logic [4:0] d);
        bus1.dato       = d;
        bus1.dato_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.dato_valid = 1'b0;
    endtask

    task automatic accept2(input logic [7:0] d);
        bus2.dato       = d;
        bus2.dato_valid = 1'b1;
        @(posedge clk);
        #1;
        bus2.dato_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg1(input logic [1:0] m, input logic [4:0] alto, input logic [4:0] bajo,
                        input logic [3:0] p);
        bus1.modo        = m;
        bus1.umbral_alto = alto;
        bus1.umbral_bajo = bajo;
        bus1.persist     = p;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        rst_n = 1'b0;
        bus1.enable = 1'b0; bus1.dato_valid = 1'b0; bus1.dato = '0;
        cfg1(2'b00, 5'd0, 5'd0, 4'd0);
        bus2.enable = 1'b0; bus2.dato_valid = 1'b0; bus2.dato = '0;
        bus2.modo = 2'b00; bus2.umbral_alto = '0; bus2.umbral_bajo = '0; bus2.persist = '0;
        #3;
        got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja, bus1.cuenta};
        n_checks++;
        if (got !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required %b", got, 7'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus1.enable = 1'b1;
        idle(1);
    endtask

    task automatic test_ge();
        logic [4:0] dv [3];
        logic [2:0] ev [3];
        logic [2:0] got;
        dv = '{5'd9, 5'd10, 5'd3};
        ev = '{3'b000, 3'b110, 3'b001};
        cfg1(2'b00, 5'd10, 5'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            accept1(dv[i]);
            got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja};
            n_checks++;
            if (got !== ev[i]) begin
                n_fail++;
                $display("FAIL ge[%0d] dato=%0d: {salida,sube,baja} got %b required %b",
                         i, dv[i], got, ev[i]);
            end
        end
    endtask

    task automatic test_window();
        logic [4:0] dv [6];
        logic [2:0] ev [6];
        logic [2:0] got;
        dv = '{5'd4, 5'd5, 5'd20, 5'd21, 5'd31, 5'd10};
        ev = '{3'b000, 3'b110, 3'b100, 3'b001, 3'b000, 3'b110};
        cfg1(2'b10, 5'd20, 5'd5, 4'd0);
        for (int i = 0; i < 6; i++) begin
            accept1(dv[i]);
            got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja};
            n_checks++;
            if (got !== ev[i]) begin
                n_fail++;
                $display("FAIL window[%0d] dato=%0d: {salida,sube,baja} got %b required %b",
                         i, dv[i], got, ev[i]);
            end
        end
        cfg1(2'b10, 5'd5, 5'd20, 4'd0);
        accept1(5'd10);
        got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja};
        n_checks++;
        if (got !== 3'b001) begin
            n_fail++;
            $display("FAIL window_inverted: {salida,sube,baja} got %b required %b", got, 3'b001);
        end
    endtask

    task automatic test_hyst();
        logic [4:0] dv [6];
        logic [2:0] ev [6];
        logic [2:0] got;
        dv = '{5'd10, 5'd16, 5'd12, 5'd8, 5'd7, 5'd12};
        ev = '{3'b000, 3'b110, 3'b100, 3'b100, 3'b001, 3'b000};
        cfg1(2'b11, 5'd16, 5'd8, 4'd0);
        for (int i = 0; i < 6; i++) begin
            accept1(dv[i]);
            got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja};
            n_checks++;
            if (got !== ev[i]) begin
                n_fail++;
                $display("FAIL hyst[%0d] dato=%0d: {salida,sube,baja} got %b required %b",
                         i, dv[i], got, ev[i]);
            end
        end
        cfg1(2'b11, 5'd16, 5'd20, 4'd0);
        accept1(5'd17);
        got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja};
        n_checks++;
        if (got !== 3'b110) begin
            n_fail++;
            $display("FAIL hyst_set_priority: {salida,sube,baja} got %b required %b", got, 3'b110);
        end
    endtask

    task automatic test_persist(input bit gaps);
        logic [4:0] dv [6];
        logic [5:0] ev [6];
        logic [5:0] got;
        dv = '{5'd12, 5'd12, 5'd5, 5'd12, 5'd12, 5'd12};
        ev = '{6'b000001, 6'b000010, 6'b000000, 6'b000001, 6'b000010, 6'b110000};
        cfg1(2'b00, 5'd10, 5'd0, 4'd0);
        accept1(5'd0);
        got = {bus1.salida, bus1.cruce_baja, bus1.cuenta};
        n_checks++;
        if (got !== 6'b010000) begin
            n_fail++;
            $display("FAIL persist_prep gaps=%0d: {salida,baja,cuenta} got %b required %b",
                     gaps, got, 6'b010000);
        end
        bus1.persist = 4'd2;
        for (int i = 0; i < 6; i++) begin
            accept1(dv[i]);
            got = {bus1.salida, bus1.cruce_sube, bus1.cuenta};
            n_checks++;
            if (got !== ev[i]) begin
                n_fail++;
                $display("FAIL persist gaps=%0d [%0d]: {salida,sube,cuenta} got %b required %b",
                         gaps, i, got, ev[i]);
            end
            if (gaps) begin
                idle(1);
                got = {bus1.salida, bus1.cruce_sube, bus1.cuenta};
                n_checks++;
                if (got !== {ev[i][5], 1'b0, ev[i][3:0]}) begin
                    n_fail++;
                    $display("FAIL persist_gap[%0d]: {salida,sube,cuenta} got %b required %b",
                             i, got, {ev[i][5], 1'b0, ev[i][3:0]});
                end
            end
        end
    endtask

    task automatic test_enable_and_reset();
        logic [6:0] got;
        cfg1(2'b00, 5'd10, 5'd0, 4'd0);
        accept1(5'd0);
        bus1.persist = 4'd3;
        accept1(5'd12);
        accept1(5'd12);
        n_checks++;
        if (bus1.cuenta !== 4'd2) begin
            n_fail++;
            $display("FAIL enable_pre: cuenta got %0d required 2", bus1.cuenta);
        end
        bus1.enable = 1'b0;
        bus1.dato_valid = 1'b1;
        idle(1);
        bus1.dato_valid = 1'b0;
        bus1.enable = 1'b1;
        got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja, bus1.cuenta};
        n_checks++;
        if (got !== 7'b0) begin
            n_fail++;
            $display("FAIL enable_low: {salida,sube,baja,cuenta} got %b required %b", got, 7'b0);
        end
        bus1.persist = 4'd0;
        accept1(5'd12);
        bus1.persist = 4'd3;
        accept1(5'd3);
        accept1(5'd3);
        got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja, bus1.cuenta};
        n_checks++;
        if (got !== 7'b1000010) begin
            n_fail++;
            $display("FAIL reset_pre: {salida,sube,baja,cuenta} got %b required %b",
                     got, 7'b1000010);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja, bus1.cuenta};
        n_checks++;
        if (got !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_async: {salida,sube,baja,cuenta} got %b required %b", got, 7'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja, bus1.cuenta};
        n_checks++;
        if (got !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_release: {salida,sube,baja,cuenta} got %b required %b",
                     got, 7'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] dv [4];
        logic [2:0] ev [4];
        logic [2:0] got;
        dv = '{5'd12, 5'd3, 5'd12, 5'd12};
        ev = '{3'b110, 3'b001, 3'b110, 3'b100};
        cfg1(2'b00, 5'd10, 5'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            accept1(dv[i]);
            got = {bus1.salida, bus1.cruce_sube, bus1.cruce_baja};
            n_checks++;
            if (got !== ev[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d] dato=%0d: {salida,sube,baja} got %b required %b",
                         i, dv[i], got, ev[i]);
            end
        end
    endtask

    task automatic test_wide_lt();
        logic [7:0] dv [8];
        logic [4:0] ev [8];
        logic [4:0] got;
        dv = '{8'd199, 8'd199, 8'd199, 8'd199, 8'd255, 8'd255, 8'd255, 8'd255};
        ev = '{5'b00001, 5'b00010, 5'b00011, 5'b11000,
               5'b10001, 5'b10010, 5'b10011, 5'b00100};
        bus2.enable = 1'b1;
        bus2.modo = 2'b01;
        bus2.umbral_bajo = 8'd200;
        bus2.umbral_alto = 8'd0;
        bus2.persist = 2'd3;
        for (int i = 0; i < 8; i++) begin
            accept2(dv[i]);
            got = {bus2.salida, bus2.cruce_sube, bus2.cruce_baja, bus2.cuenta};
            n_checks++;
            if (got !== ev[i]) begin
                n_fail++;
                $display("FAIL wide_lt[%0d] dato=%0d: {salida,sube,baja,cuenta} got %b required %b",
                         i, dv[i], got, ev[i]);
            end
        end
        idle(1);
        got = {bus2.salida, bus2.cruce_sube, bus2.cruce_baja, bus2.cuenta};
        n_checks++;
        if (got !== 5'b0) begin
            n_fail++;
            $display("FAIL wide_lt_after: {salida,sube,baja,cuenta} got %b required %b",
                     got, 5'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ge();
        test_window();
        test_hyst();
        test_persist(1'b0);
        test_persist(1'b1);
        test_enable_and_reset();
        test_back_to_back();
        test_wide_lt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
